// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer feeding a 2-entry instruction FIFO to decode
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_DEPTH  = 10,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        busy,
  output logic        fault
);
  typedef enum logic [1:0] {BOOT, FETCH, HALT, FAULT} state_e;
  localparam int BC = BOOT_CYCLES < 1 ? 1 : BOOT_CYCLES;
  localparam int CW = BC > 1 ? $clog2(BC) : 1;
  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);
  state_e state_q, state_d, boot_next;
  logic [CW-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] fifo_q [2];
  logic head_q, tail_q;
  logic [1:0] cnt_q;
  logic pop, push, flush, boot_done, pc_bad, redir_bad;

  assign imem_addr = {2'b00, pc_q[31:2]};
  assign dec_valid = cnt_q != 2'd0;
  assign dec_pc = dec_valid ? fifo_q[head_q][63:32] : '0;
  assign dec_inst = dec_valid ? fifo_q[head_q][31:0] : '0;
  assign busy = state_q == FETCH;
  assign fault = state_q == FAULT;
  assign pop = dec_valid & dec_ready;
  assign boot_done = boot_cnt_q == CW'(BC - 1);
  assign boot_next = boot_done ? FETCH : BOOT;
  assign pc_bad = imem_addr >= DEPTH;
  assign redir_bad = (redirect_pc[1:0] != 2'b00) | ({2'b00, redirect_pc[31:2]} >= DEPTH);

  // next state: a redirect overrides everything, otherwise per-state fetch decision
  always_comb begin
    state_d = state_q;
    boot_cnt_d = state_q == BOOT ? boot_cnt_q + CW'(1) : boot_cnt_q;
    pc_d = pc_q;
    push = 1'b0;
    flush = redirect_valid;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      state_d = redir_bad ? FAULT :
                state_q == BOOT ? boot_next :
                state_q == HALT ? HALT :
                (state_q == FETCH && halt_req) ? HALT : FETCH;
    end else begin
      unique case (state_q)
        BOOT: state_d = boot_next;
        FETCH: begin
          if (pc_bad) state_d = FAULT;
          else if (halt_req) state_d = HALT;
          else if (cnt_q != 2'd2 || pop) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        HALT: state_d = (resume && !halt_req) ? FETCH : HALT;
        default: ;
      endcase
    end
  end

  // control state: FSM, boot counter and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      boot_cnt_q <= '0;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q <= pc_d;
    end
  end

  // 2-entry FIFO of {pc, inst}; a redirect discards it wholesale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) fifo_q[tail_q] <= {pc_q, imem_inst};
      head_q <= head_q ^ pop;
      tail_q <= tail_q ^ push;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and random checks of the fetch sequencer against a queue model
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 10;
  localparam int BC = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_inst, dec_inst, dec_pc, redirect_pc;
  logic dec_valid, dec_ready, redirect_valid, halt_req, resume, busy, fault;
  logic [31:0] mem [16];
  int tests = 0, fails = 0;
  int m_mode, m_boot;
  logic [31:0] m_pc, last;
  logic [63:0] q [$];

  always #5 clk = ~clk;

  assign imem_inst = (imem_addr < DEPTH) ? mem[imem_addr[3:0]] : 32'hdead_beef;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .resume(resume), .busy(busy), .fault(fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT;
    m_boot = 0;
    m_pc = 32'h0;
    q.delete();
  endtask

  // advance the model by the coming clock edge, using the inputs now applied
  task automatic model_update();
    bit pop, full;
    if (!rst_n) return;
    pop = q.size() != 0 && dec_ready;
    full = q.size() == 2;
    if (m_mode == M_BOOT) m_boot++;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00 || !in_range(redirect_pc)) m_mode = M_FAULT;
      else if (m_mode == M_BOOT) m_mode = m_boot >= BC ? M_RUN : M_BOOT;
      else if (m_mode == M_FAULT) m_mode = M_RUN;
      else if (m_mode == M_RUN && halt_req) m_mode = M_HALT;
    end else begin
      if (pop) void'(q.pop_front());
      case (m_mode)
        M_BOOT: if (m_boot >= BC) m_mode = M_RUN;
        M_RUN: begin
          if (!in_range(m_pc)) m_mode = M_FAULT;
          else if (halt_req) m_mode = M_HALT;
          else if (!full || pop) begin
            q.push_back({m_pc, mem[m_pc[5:2]]});
            m_pc = m_pc + 32'd4;
          end
        end
        M_HALT: if (resume && !halt_req) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("dec_valid", dec_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("dec_pc", dec_pc, q[0][63:32]);
      chk("dec_inst", dec_inst, q[0][31:0]);
    end
    chk("imem_addr", imem_addr, m_pc >> 2);
    chk("busy", busy, m_mode == M_RUN);
    chk("fault", fault, m_mode == M_FAULT);
  endtask

  task automatic cyc();
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt_req = 1'b0;
    resume = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_inst", dec_inst, 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t1_not_yet", dec_valid, 0);
    cyc();
    chk("t1_first_valid", dec_valid, 1);
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_inst0", dec_inst, mem[0]);
    cyc();
    chk("t1_pc4", dec_pc, 32'h4);
    cyc();
    chk("t1_pc8", dec_pc, 32'h8);
    do_reset();
    dec_ready = 1'b0;
    repeat (8) cyc();
    chk("t2_addr_frozen", imem_addr, 32'd2);
    chk("t2_head", dec_pc, 32'h0);
    dec_ready = 1'b1;
    cyc();
    chk("t2_pc4", dec_pc, 32'h4);
    cyc();
    chk("t2_pc8", dec_pc, 32'h8);
    dec_ready = 1'b0;
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_flush", dec_valid, 0);
    chk("t3_addr", imem_addr, 32'd4);
    cyc();
    chk("t3_valid", dec_valid, 1);
    chk("t3_pc", dec_pc, 32'h10);
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_fault", fault, 1);
    chk("t4_busy", busy, 0);
    repeat (3) cyc();
    chk("t4_no_push", dec_valid, 0);
    chk("t4_addr", imem_addr, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_fault_clr", fault, 0);
    chk("t4_busy_again", busy, 1);
    chk("t4_addr0", imem_addr, 32'd0);
    cyc();
    chk("t4_restart", dec_pc, 32'h0);
    last = 32'hffff_ffff;
    repeat (20) begin
      cyc();
      if (dec_valid) last = dec_pc;
    end
    chk("t5_last_pc", last, 32'h24);
    chk("t5_fault", fault, 1);
    chk("t5_drained", dec_valid, 0);
    chk("t5_addr", imem_addr, 32'd10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_pre_halt", dec_pc, 32'h4);
    halt_req = 1'b1;
    repeat (3) cyc();
    chk("t6_halted", busy, 0);
    chk("t6_no_push", dec_valid, 0);
    chk("t6_held_addr", imem_addr, 32'd2);
    halt_req = 1'b0;
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t6_resumed", busy, 1);
    cyc();
    chk("t6_continue", dec_pc, 32'h8);
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", dec_valid, 0);
    chk("t6_async_addr", imem_addr, 0);
    chk("t6_async_busy", busy, 0);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    repeat (3000) begin
      dec_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      case ($urandom_range(0, 9))
        0: redirect_pc = $urandom_range(0, 63);
        1: redirect_pc = $urandom;
        default: redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      endcase
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      resume = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else rst_n = 1'b1;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
